// File: rtl/fabric_pkg.sv
// fabric_pkg: shared index helpers, parameter error codes and round-robin pick function
package fabric_pkg;
  localparam int MAX_IN = 64;
  localparam int IDX_W  = 6;
  localparam string COMP_TAG_ARB_NUM_IN     = "COMP_TAG_ARB_NUM_IN: NUM_IN must be in 2..64";
  localparam string COMP_TAG_ARB_DATA_WIDTH = "COMP_TAG_ARB_DATA_WIDTH: DATA_WIDTH must be >= 1";
  localparam string COMP_TAG_ARB_TAG_WIDTH  = "COMP_TAG_ARB_TAG_WIDTH: TAG_WIDTH must be >= 1 and >= clog2(NUM_IN)";
  localparam string COMP_TAG_ARB_BURST_LEN  = "COMP_TAG_ARB_BURST_LEN: BURST_LEN must be >= 1";
  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } pick_t;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  // first set bit of valid searching ptr, ptr+1, ... modulo n
  function automatic pick_t rr_pick(input logic [MAX_IN-1:0] valid, input int n, input int ptr);
    pick_t p;
    int i;
    p = '0;
    for (int k = 0; k < MAX_IN; k++) begin
      i = (ptr + k) % n;
      if (k < n && !p.found && valid[i]) begin
        p.found = 1'b1;
        p.idx   = IDX_W'(i);
      end
    end
    return p;
  endfunction
endpackage

// File: rtl/fabric_rr_arbiter.sv
// fabric_rr_arbiter: combinational round-robin priority rotation starting at ptr
module fabric_rr_arbiter import fabric_pkg::*; #(
  parameter int N = 4,
  localparam int W = idx_w(N)
) (
  input  logic [N-1:0] valid,
  input  logic [W-1:0] ptr,
  output logic         found,
  output logic [W-1:0] idx
);
  logic [MAX_IN-1:0] v;
  pick_t p;
  always_comb begin
    v = '0;
    v[N-1:0] = valid;
    p = rr_pick(v, N, int'(ptr));
  end
  assign found = p.found;
  assign idx   = W'(p.idx);
endmodule

// File: rtl/fabric_tag_arbiter.sv
// fabric_tag_arbiter: N-to-1 round-robin arbiter with burst allowance that tags each beat
module fabric_tag_arbiter import fabric_pkg::*; #(
  parameter int NUM_IN     = 4,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 4,
  parameter int BURST_LEN  = 4,
  localparam int CONFIG_WIDTH = NUM_IN * TAG_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_IN-1:0]               in_valid,
  output logic [NUM_IN-1:0]               in_ready,
  input  logic [NUM_IN*DATA_WIDTH-1:0]    in_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [TAG_WIDTH+DATA_WIDTH-1:0] out_data,
  input  logic [CONFIG_WIDTH-1:0]         cfg_data,
  output logic                            cfg_err
);
  localparam int IW = idx_w(NUM_IN);
  localparam int CW = idx_w(BURST_LEN);
  localparam logic [CW-1:0] BMAX = CW'(BURST_LEN - 1);
  localparam logic [IW-1:0] LAST = IW'(NUM_IN - 1);

  if (NUM_IN < 2 || NUM_IN > MAX_IN) begin : g_bad_num_in
    $fatal(1, "%s", COMP_TAG_ARB_NUM_IN);
  end
  if (DATA_WIDTH < 1) begin : g_bad_data_width
    $fatal(1, "%s", COMP_TAG_ARB_DATA_WIDTH);
  end
  if (TAG_WIDTH < 1 || TAG_WIDTH < $clog2(NUM_IN)) begin : g_bad_tag_width
    $fatal(1, "%s", COMP_TAG_ARB_TAG_WIDTH);
  end
  if (BURST_LEN < 1) begin : g_bad_burst_len
    $fatal(1, "%s", COMP_TAG_ARB_BURST_LEN);
  end

  logic [IW-1:0] rr_ptr, owner, arb_idx, grant;
  logic [CW-1:0] burst_cnt;
  logic          arb_found, hold, can_load, load, dup;

  fabric_rr_arbiter #(.N(NUM_IN)) u_rr (
    .valid(in_valid),
    .ptr  (rr_ptr),
    .found(arb_found),
    .idx  (arb_idx)
  );

  // owner keeps the grant while it stays valid and has burst allowance left
  assign hold     = in_valid[owner] && burst_cnt < BMAX;
  assign grant    = hold ? owner : arb_idx;
  assign can_load = !out_valid || out_ready;
  assign in_ready = ((hold || arb_found) && can_load && !rst) ? NUM_IN'(1) << grant : '0;
  assign load     = |(in_valid & in_ready);

  always_comb begin
    dup = 1'b0;
    for (int i = 0; i < NUM_IN; i++)
      for (int j = i + 1; j < NUM_IN; j++)
        dup = dup | (cfg_data[i*TAG_WIDTH +: TAG_WIDTH] == cfg_data[j*TAG_WIDTH +: TAG_WIDTH]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      cfg_err   <= 1'b0;
      rr_ptr    <= '0;
      owner     <= '0;
      burst_cnt <= '0;
    end else begin
      cfg_err <= dup;
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= {cfg_data[grant*TAG_WIDTH +: TAG_WIDTH], in_data[grant*DATA_WIDTH +: DATA_WIDTH]};
        owner     <= grant;
        burst_cnt <= hold ? burst_cnt + 1'b1 : '0;
        rr_ptr    <= (grant == LAST) ? '0 : grant + 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fabric_tag_arbiter.sv
// tb_fabric_tag_arbiter: directed checks of grant order, tagging, back-pressure and cfg_err
module tb_fabric_tag_arbiter;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   in_valid = '0;
  logic [3:0]   in_ready;
  logic [127:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [35:0]  out_data;
  logic [15:0]  cfg_data = 16'hC953;
  logic         cfg_err;
  int checks = 0;
  int errors = 0;
  int order [8] = '{1, 1, 2, 2, 3, 3, 0, 0};
  logic [35:0] beat [4] = '{36'h3_11111111, 36'h5_22222222, 36'h9_33333333, 36'hC_44444444};

  fabric_tag_arbiter #(.NUM_IN(4), .DATA_WIDTH(32), .TAG_WIDTH(4), .BURST_LEN(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .cfg_data (cfg_data),
    .cfg_err  (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  initial begin
    in_data  = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    in_valid = 4'hF;
    out_ready = 1'b1;
    rst = 1'b1;
    tick;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_cfg_err", 64'(cfg_err), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    tick;
    chk("rst_in_ready2", 64'(in_ready), 64'd0);
    chk("rst_out_valid2", 64'(out_valid), 64'd0);
    rst = 1'b0;
    #1;
    chk("first_grant", 64'(in_ready), 64'b0001);
    tick;
    chk("first_beat", 64'(out_data), 64'(beat[0]));
    chk("first_valid", 64'(out_valid), 64'd1);
    for (int k = 0; k < 8; k++) begin
      tick;
      chk($sformatf("rr_beat%0d", k), 64'(out_data), 64'(beat[order[k]]));
      chk($sformatf("rr_valid%0d", k), 64'(out_valid), 64'd1);
    end
    chk("rr_cfg_err", 64'(cfg_err), 64'd0);
    in_valid = 4'b0100;
    in_data[64 +: 32] = 32'hDEADBEEF;
    #1;
    chk("solo_grant", 64'(in_ready), 64'b0100);
    for (int k = 0; k < 4; k++) begin
      tick;
      chk($sformatf("solo_beat%0d", k), 64'(out_data), 64'h9_DEADBEEF);
      chk($sformatf("solo_valid%0d", k), 64'(out_valid), 64'd1);
      chk($sformatf("solo_ready%0d", k), 64'(in_ready), 64'b0100);
    end
    out_ready = 1'b0;
    in_data[64 +: 32] = 32'hCAFEF00D;
    #1;
    chk("bp_ready0", 64'(in_ready), 64'd0);
    for (int k = 0; k < 5; k++) begin
      tick;
      chk($sformatf("bp_data%0d", k), 64'(out_data), 64'h9_DEADBEEF);
      chk($sformatf("bp_valid%0d", k), 64'(out_valid), 64'd1);
      chk($sformatf("bp_ready%0d", k), 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_grant", 64'(in_ready), 64'b0100);
    tick;
    chk("bp_release_data", 64'(out_data), 64'h9_CAFEF00D);
    chk("bp_release_valid", 64'(out_valid), 64'd1);
    in_valid = 4'b0010;
    #1;
    chk("own1_grant", 64'(in_ready), 64'b0010);
    tick;
    chk("own1_data", 64'(out_data), 64'h5_22222222);
    in_valid = 4'b1100;
    #1;
    chk("drop_grant", 64'(in_ready), 64'b0100);
    tick;
    chk("drop_data", 64'(out_data), 64'h9_CAFEF00D);
    chk("drop_hold_grant", 64'(in_ready), 64'b0100);
    tick;
    chk("drop_hold_data", 64'(out_data), 64'h9_CAFEF00D);
    chk("drop_rotate_grant", 64'(in_ready), 64'b1000);
    tick;
    chk("drop_rotate_data", 64'(out_data), 64'hC_44444444);
    in_valid = 4'b0000;
    cfg_data = 16'h7957;
    tick;
    chk("dup03_err", 64'(cfg_err), 64'd1);
    chk("drain_valid", 64'(out_valid), 64'd0);
    chk("drain_data", 64'(out_data), 64'hC_44444444);
    chk("idle_ready", 64'(in_ready), 64'd0);
    cfg_data = 16'hC953;
    tick;
    chk("fix_err", 64'(cfg_err), 64'd0);
    cfg_data = 16'hC553;
    tick;
    chk("dup12_err", 64'(cfg_err), 64'd1);
    cfg_data = 16'hC953;
    tick;
    chk("fix_err2", 64'(cfg_err), 64'd0);
    in_valid = 4'hF;
    #1;
    chk("pre_rst_grant", 64'(in_ready), 64'b1000);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", 64'(in_ready), 64'd0);
    tick;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_data", 64'(out_data), 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_grant", 64'(in_ready), 64'b0001);
    tick;
    chk("post_rst_beat", 64'(out_data), 64'(beat[0]));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
